// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// instr_encoder: packs symbolic RISC-V instructions (RV32I subset) into
// machine words and streams them into instruction memory at consecutive
// word addresses.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, base_addr  begin a program at base_addr (low two bits dropped)
//   finish            end the program (RUN only)
//   in_valid/in_ready symbolic instruction handshake (ready == RUN)
//   op, rd, rs1, rs2, imm   symbolic instruction fields
//   mem_we/mem_addr/mem_wdata  registered instruction-memory write port
//   done              one-cycle end-of-program pulse
//   err               sticky: some instruction failed its range check
//   count             words written since start
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SLL = 4'd2,
                         OP_XOR = 4'd3,  OP_SRL = 4'd4,  OP_OR  = 4'd5,
                         OP_AND = 4'd6,  OP_ADDI = 4'd7, OP_LBU = 4'd8,
                         OP_SB  = 4'd9,  OP_BEQ = 4'd10, OP_BNE = 4'd11,
                         OP_LUI = 4'd12, OP_AUIPC = 4'd13, OP_JAL = 4'd14,
                         OP_JALR = 4'd15;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [31:0]       enc;
  logic              legal;
  logic              fire;
  logic              start_ld;
  logic signed [31:0] simm;

  assign in_ready = (state == RUN);
  assign done     = (state == DONE);
  assign fire     = in_valid && in_ready;
  assign start_ld = start && (state != RUN);
  assign simm     = imm;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Encoder + range check. legal only matters when the word is transferred.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:  enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SUB:  enc = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SLL:  enc = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
      OP_XOR:  enc = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      OP_SRL:  enc = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0110011};
      OP_OR:   enc = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      OP_AND:  enc = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      OP_ADDI, OP_LBU, OP_JALR: begin
        legal = (simm >= -2048) && (simm <= 2047);
        enc   = {imm[11:0], rs1,
                 (op == OP_LBU) ? 3'b100 : 3'b000, rd,
                 (op == OP_ADDI) ? 7'b0010011 :
                 (op == OP_LBU)  ? 7'b0000011 : 7'b1100111};
      end
      OP_SB: begin
        legal = (simm >= -2048) && (simm <= 2047);
        enc   = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
      end
      OP_BEQ, OP_BNE: begin
        legal = (simm >= -4096) && (simm <= 4094) && !imm[0];
        enc   = {imm[12], imm[10:5], rs2, rs1,
                 (op == OP_BNE) ? 3'b001 : 3'b000,
                 imm[4:1], imm[11], 7'b1100011};
      end
      OP_LUI, OP_AUIPC: begin
        legal = (imm[11:0] == 12'd0);
        enc   = {imm[31:12], rd, (op == OP_LUI) ? 7'b0110111 : 7'b0010111};
      end
      OP_JAL: begin
        legal = (simm >= -1048576) && (simm <= 1048574) && !imm[0];
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      default: ;
    endcase
  end

  // wptr advances at the transfer edge so back-to-back words get
  // consecutive addresses; count trails by one cycle because it follows
  // the registered write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= fire && legal;
      if (fire && legal) begin
        mem_addr  <= wptr;
        mem_wdata <= enc;
        wptr      <= wptr + ADDR_W'(4);
      end
      if (start_ld) begin
        wptr  <= {base_addr[ADDR_W-1:2], 2'b00};
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (mem_we)          count <= count + ADDR_W'(1);
        if (fire && !legal)  err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst, start, finish, in_valid, in_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        op;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic              mem_we, done, err;
  logic [ADDR_W-1:0] mem_addr, count;
  logic [31:0]       mem_wdata;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+31:0] sb_q[$];   // {addr, word}
  logic [ADDR_W-1:0]  wptr_m;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        logic [ADDR_W+31:0] e;
        e = sb_q.pop_front();
        chk("waddr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
        chk("wdata", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1; base_addr = b; wptr_m = {b[ADDR_W-1:2], 2'b00};
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input bit ok,
                       input logic [31:0] word, input bit fin = 1'b0);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1; finish = fin;
    if (ok) begin
      sb_q.push_back({wptr_m, word});
      wptr_m = wptr_m + ADDR_W'(4);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 0; finish = 0; in_valid = 0; base_addr = '0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; wptr_m = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we",   32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_wdata",    mem_wdata, 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_err",      32'(err), 0);
    chk("rst_count",    32'(count), 0);
    rst = 1'b0;

    // Basic R/I encodings
    do_start(12'h100);
    chk("run_ready", 32'(in_ready), 1);
    issue(4'd7, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
    issue(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3);
    issue(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3);
    tick();
    chk("count3", 32'(count), 3);

    // B/J/U/S encodings
    issue(4'd11, 5'd0, 5'd1, 5'd2, -32'sd8, 1, 32'hFE209CE3);
    issue(4'd14, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h008000EF);
    issue(4'd12, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 32'h123452B7);
    issue(4'd9,  5'd0, 5'd1, 5'd2, 32'd3, 1, 32'h002081A3);
    tick();
    chk("count7", 32'(count), 7);

    // Out-of-range immediates: accepted, flagged, not written
    issue(4'd7,  5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'h0);
    issue(4'd10, 5'd0, 5'd1, 5'd2, 32'd3, 0, 32'h0);
    issue(4'd12, 5'd5, 5'd0, 5'd0, 32'h12345001, 0, 32'h0);
    chk("err_set", 32'(err), 1);
    chk("count_hold", 32'(count), 7);
    issue(4'd7, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
    tick();
    chk("count8", 32'(count), 8);
    chk("err_sticky", 32'(err), 1);

    // start while RUN is ignored; address keeps running from 0x120
    start = 1'b1; base_addr = 12'h200;
    issue(4'd3, 5'd4, 5'd5, 5'd6, 32'd0, 1, 32'h0062C233);
    start = 1'b0;
    chk("start_ignored_err", 32'(err), 1);

    // finish together with a transfer: write and done coincide
    issue(4'd13, 5'd7, 5'd0, 5'd0, 32'h00001000, 1, 32'h00001397, 1'b1);
    chk("done_pulse", 32'(done), 1);
    chk("done_we", 32'(mem_we), 1);
    chk("done_ready", 32'(in_ready), 0);
    tick();
    chk("done_clear", 32'(done), 0);
    chk("idle_ready", 32'(in_ready), 0);
    chk("count10", 32'(count), 10);

    // New program clears err/count; wptr wraps at the top of memory
    do_start(12'hFFE);
    chk("start_err_clr", 32'(err), 0);
    chk("start_cnt_clr", 32'(count), 0);
    issue(4'd15, 5'd1, 5'd2, 5'd0, 32'd4, 1, 32'h004100E7);
    issue(4'd8,  5'd3, 5'd2, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF14183);
    tick();
    chk("count_wrap", 32'(count), 2);

    // finish alone, then start during DONE goes straight back to RUN
    finish = 1'b1; tick(); finish = 1'b0;
    chk("done_only", 32'(done), 1);
    do_start(12'h040);
    chk("done_to_run", 32'(in_ready), 1);

    // Back-to-back stream, reset mid-stream
    for (int i = 0; i < 8; i++)
      issue(4'd7, 5'd1, 5'd0, 5'd0, 32'(i), 1, {12'(i), 20'h00093});
    rst = 1'b1; in_valid = 1'b1; op = 4'd7; imm = 32'd9;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_we",    32'(mem_we), 0);
    chk("mrst_addr",  32'(mem_addr), 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_err",   32'(err), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_ready", 32'(in_ready), 0);
    chk("mrst_done",  32'(done), 0);
    repeat (4) tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder that builds machine code for the instruction subset the control unit decodes: R-type ADD/SUB/SLL/XOR/SRL/OR/AND, ADDI, LBU, SB, BEQ, BNE, LUI, AUIPC, JAL and JALR. Each symbolic instruction arrives over a valid/ready handshake, is range-checked, packed into a 32-bit word, and written to consecutive instruction-memory addresses. It sits between the test/boot sequencer and the instruction memory's write port, and loads programs in simulation and at bring-up.

## Interface
- ADDR_W, 12, instruction-memory byte-address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; when IDLE or DONE, loads base_addr and enters RUN.
- base_addr  in  ADDR_W  first write address; bits [1:0] are forced to 0.
- finish  in  1  ends the program; sampled only in RUN.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  high exactly in RUN.
- op  in  4  0 ADD, 1 SUB, 2 SLL, 3 XOR, 4 SRL, 5 OR, 6 AND, 7 ADDI, 8 LBU, 9 SB, 10 BEQ, 11 BNE, 12 LUI, 13 AUIPC, 14 JAL, 15 JALR.
- rd, rs1, rs2  in  5 each  register indices; unused fields are ignored.
- imm  in  32  signed byte offset or immediate; for LUI/AUIPC, the full upper value.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write byte address.
- mem_wdata  out  32  encoded instruction.
- done  out  1  one-cycle pulse when the program ends.
- err  out  1  sticky flag: one or more instructions were rejected.
- count  out  ADDR_W  number of words written since start.

## Operation
- FSM states:
  - IDLE: start -> RUN.
  - RUN: finish -> DONE.
  - DONE: done=1 for this cycle only, then -> IDLE; a start in DONE -> RUN.
  - start in RUN is ignored.
- On start: wptr=base_addr & ~3, count=0, err=0.
- A transfer occurs when in_valid && in_ready. The encoded word is registered, so mem_we/mem_addr/mem_wdata are valid in the following cycle.
- Each write increments wptr by 4 and count by 1. wptr wraps modulo 2^ADDR_W with no error.
- Opcode/funct encodings:
  - R-type: opcode 0110011; funct7=0100000 for SUB, 0 otherwise; funct3 ADD/SUB 000, SLL 001, XOR 100, SRL 101, OR 110, AND 111.
  - I-type: ADDI 0010011/000, LBU 0000011/100, JALR 1100111/000; imm[11:0]->[31:20].
  - S-type: SB 0100011/000; imm[11:5]->[31:25], imm[4:0]->[11:7].
  - B-type: 1100011; BEQ funct3 000, BNE 001; [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U-type: LUI 0110111, AUIPC 0010111; [31:12]=imm[31:12].
  - J-type: JAL 1101111; [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range rules (a violation rejects the instruction):
  - I/S: -2048..2047.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - U: imm[11:0] must be 0.
  - R: imm is ignored.
- A rejected instruction is still accepted (handshake completes) but sets err. It causes no write, and wptr and count are unchanged.
- Simultaneous finish and transfer: the instruction is accepted, and its write occurs in the DONE cycle alongside the done pulse.

## Timing
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, count=0.
- Latency: transfer at edge N -> mem_we=1 during cycle N+1 with the old wptr; count updates at edge N+1.
- Throughput: one instruction per cycle; no backpressure other than state.
- mem_we is a single-cycle pulse per accepted, legal instruction; mem_addr/mem_wdata hold their last values when mem_we=0.
- rst mid-RUN: at that edge, everything returns to reset values; a write pending from the previous cycle is dropped.

## Test plan
- start base_addr=0x100; ADDI x1,x0,5; ADD x3,x1,x2; SUB x3,x1,x2 -> writes 0x00500093@0x100, 0x002081B3@0x104, 0x402081B3@0x108; count=3.
- BNE x1,x2,-8; JAL x1,8; LUI x5,0x12345000; SB x2,3(x1) -> 0xFE209CE3, 0x008000EF, 0x123452B7, 0x002081A3 at consecutive addresses.
- ADDI imm=2048; BEQ imm=3; LUI imm=0x12345001 -> no writes, err=1, wptr unchanged; the next legal instruction writes to the original address.
- base_addr=0xFFC (ADDR_W=12), two legal instructions -> writes at 0xFFC then 0x000.
- finish with in_valid in the same cycle -> last write and done pulse coincide; in_ready=0 afterwards; a new start clears err and count.
- Back-to-back valid for 8 cycles, then rst asserted mid-stream -> all outputs 0 the next cycle and no further mem_we.
